// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised inter-stage pipeline register with valid/ready
//                handshake, optional two-entry skid buffer, flush-to-bubble
//                (ctrl and rd zeroed, data kept) and a saturating flush
//                counter. All state updates on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 160,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Main entry: drives the outputs directly.
    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [RD_W-1:0]   r_main_rd;

    // Skid entry: holds a beat accepted while main is blocked downstream.
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [RD_W-1:0]   r_skid_rd;

    logic [CNT_W-1:0]  r_flush_count;

    logic w_room;
    logic w_in_ready;
    logic w_accept;
    logic w_drain;

    // Acceptance: never while in reset, flushing or stalled.
    assign w_in_ready = rst_n && !flush && !stall && w_room;
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = r_main_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // With a skid entry, room only depends on the skid being empty,
            // so in_ready is independent of out_ready.
            assign w_room = !r_skid_valid;

            // Skid entry: filled on accept while main is blocked, emptied
            // when main takes it over; flush kills it (data retained).
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_data  <= '0;
                    r_skid_rd    <= '0;
                end else if (flush) begin
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_rd    <= '0;
                end else if (w_drain && r_skid_valid) begin
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_rd    <= '0;
                end else if (w_accept && r_main_valid && !w_drain) begin
                    r_skid_valid <= 1'b1;
                    r_skid_ctrl  <= in_ctrl;
                    r_skid_data  <= in_data;
                    r_skid_rd    <= in_rd;
                end
            end
        end else begin : g_no_skid
            // Single register: accept only if main is empty or draining.
            assign w_room       = !r_main_valid || out_ready;
            assign r_skid_valid = 1'b0;
            assign r_skid_ctrl  = '0;
            assign r_skid_data  = '0;
            assign r_skid_rd    = '0;
        end
    endgenerate

    // Main entry: skid refill has priority over a new input so order holds;
    // an invalid main entry always presents ctrl=0 and rd=0.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_main_rd    <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_rd    <= '0;
        end else if (w_drain && r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= r_skid_ctrl;
            r_main_data  <= r_skid_data;
            r_main_rd    <= r_skid_rd;
        end else if (w_accept && (!r_main_valid || w_drain)) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= in_ctrl;
            r_main_data  <= in_data;
            r_main_rd    <= in_rd;
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_rd    <= '0;
        end
    end

    // Flush cycle counter, saturating at all-ones.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_count <= '0;
        end else if (flush && (r_flush_count != C_CNT_MAX)) begin
            r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_main_valid;
    assign out_ctrl    = r_main_ctrl;
    assign out_data    = r_main_data;
    assign out_rd      = r_main_rd;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed self-checking bench for pipe_stage_reg. Instance a
//                uses the skid buffer with a 16-bit counter; instance b is a
//                single register with a 2-bit counter. Inputs are shared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic         clk = 1'b1;
    logic         rst_n;
    logic         in_valid;
    logic [11:0]  in_ctrl;
    logic [159:0] in_data;
    logic [4:0]   in_rd;
    logic         stall;
    logic         flush;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [11:0]  a_out_ctrl;
    logic [159:0] a_out_data;
    logic [4:0]   a_out_rd;
    logic [15:0]  a_flush_count;

    logic         b_in_ready, b_out_valid;
    logic [11:0]  b_out_ctrl;
    logic [159:0] b_out_data;
    logic [4:0]   b_out_rd;
    logic [1:0]   b_flush_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(160), .RD_W(5), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .stall(stall),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .out_rd(a_out_rd),
        .flush_count(a_flush_count)
    );

    pipe_stage_reg #(.CTRL_W(12), .DATA_W(160), .RD_W(5), .SKID(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .stall(stall),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_rd(b_out_rd),
        .flush_count(b_flush_count)
    );

    // Data pattern tied to the destination so every beat is distinguishable.
    function automatic logic [159:0] pat(input logic [4:0] r);
        return {5{27'h5A5A5A5, r}};
    endfunction

    // Advance past the next (active) falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [11:0] c);
        in_valid = v;
        in_rd    = r;
        in_ctrl  = c;
        in_data  = pat(r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_rd = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 12'h0) begin n_err++; $display("FAIL reset_ctrl: got %0h want 0", a_out_ctrl); end
        n_cmp++; if (a_out_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", a_out_rd); end
        n_cmp++; if (a_out_data !== 160'h0) begin n_err++; $display("FAIL reset_data: got %0h want 0", a_out_data); end
        n_cmp++; if (a_flush_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a_flush_count); end
        in_valid = 1'b1; #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", a_in_ready); end
        in_valid = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 12'h0AB);
            #1;
            n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, a_in_ready); end
            step();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'(i) || a_out_ctrl !== 12'h0AB)
                begin n_err++; $display("FAIL stream_out[%0d]: got v=%0b rd=%0d ctrl=%0h want v=1 rd=%0d ctrl=0ab", i, a_out_valid, a_out_rd, a_out_ctrl, i); end
        end
        drive(1'b0, 5'd0, 12'h0);
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0) begin n_err++; $display("FAIL stream_drain: got v=%0b rd=%0d want v=0 rd=0", a_out_valid, a_out_rd); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 12'h017);
        step();
        drive(1'b1, 5'd9, 12'h019);
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_skid_room: got %0b want 1", a_in_ready); end
        step();
        drive(1'b0, 5'd0, 12'h0);
        #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b want 0", a_in_ready); end
        n_cmp++; if (a_out_rd !== 5'd7 || a_out_ctrl !== 12'h017) begin n_err++; $display("FAIL bp_main: got rd=%0d ctrl=%0h want rd=7 ctrl=017", a_out_rd, a_out_ctrl); end
        step();
        n_cmp++; if (a_out_rd !== 5'd7) begin n_err++; $display("FAIL bp_hold: got rd=%0d want 7", a_out_rd); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd9 || a_out_data !== pat(5'd9))
            begin n_err++; $display("FAIL bp_skid_out: got v=%0b rd=%0d want v=1 rd=9", a_out_valid, a_out_rd); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", a_in_ready); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0) begin n_err++; $display("FAIL bp_no_dup: got v=%0b rd=%0d want v=0 rd=0", a_out_valid, a_out_rd); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 5'd5, 12'hFFF);
        step();
        drive(1'b1, 5'd6, 12'hFFF);
        step();
        drive(1'b1, 5'd10, 12'h123);
        flush = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b want 0", a_in_ready); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 12'h0 || a_out_rd !== 5'd0)
            begin n_err++; $display("FAIL flush_bubble: got v=%0b ctrl=%0h rd=%0d want 0 0 0", a_out_valid, a_out_ctrl, a_out_rd); end
        n_cmp++; if (a_out_data !== pat(5'd5)) begin n_err++; $display("FAIL flush_data: got %0h want %0h", a_out_data, pat(5'd5)); end
        n_cmp++; if (a_flush_count !== 16'd1) begin n_err++; $display("FAIL flush_count: got %0d want 1", a_flush_count); end
        flush = 1'b0;
        drive(1'b0, 5'd0, 12'h0);
        out_ready = 1'b1;
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0) begin n_err++; $display("FAIL flush_skid_killed: got v=%0b rd=%0d want v=0 rd=0", a_out_valid, a_out_rd); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 12'h0AB);
        step();
        drive(1'b1, 5'd8, 12'h0CD);
        stall = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %0b want 0", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd3) begin n_err++; $display("FAIL stall_main: got v=%0b rd=%0d want v=1 rd=3", a_out_valid, a_out_rd); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_rd !== 5'd0 || a_out_ctrl !== 12'h0)
            begin n_err++; $display("FAIL stall_bubble: got v=%0b rd=%0d ctrl=%0h want 0 0 0", a_out_valid, a_out_rd, a_out_ctrl); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_accept: got v=%0b want 0", a_out_valid); end
        stall = 1'b0;
        drive(1'b0, 5'd0, 12'h0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 5'd11, 12'h011);
        step();
        drive(1'b1, 5'd12, 12'h012);
        step();
        drive(1'b0, 5'd0, 12'h0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 12'h0 || a_out_rd !== 5'd0 || a_out_data !== 160'h0)
            begin n_err++; $display("FAIL areset_outputs: got v=%0b ctrl=%0h rd=%0d data=%0h want all 0", a_out_valid, a_out_ctrl, a_out_rd, a_out_data); end
        n_cmp++; if (a_flush_count !== 16'd0 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL areset_count_ready: got cnt=%0d rdy=%0b want 0 0", a_flush_count, a_in_ready); end
        @(posedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd13, 12'h013);
        step();
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_rd !== 5'd13) begin n_err++; $display("FAIL areset_first_accept: got v=%0b rd=%0d want v=1 rd=13", a_out_valid, a_out_rd); end
        drive(1'b0, 5'd0, 12'h0);
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_noskid_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 12'h0AB);
            #1;
            n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_stream_ready[%0d]: got %0b want 1", i, b_in_ready); end
            step();
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_rd !== 5'(i)) begin n_err++; $display("FAIL ns_stream_out[%0d]: got v=%0b rd=%0d want v=1 rd=%0d", i, b_out_valid, b_out_rd, i); end
        end
        drive(1'b0, 5'd0, 12'h0);
        step();
    endtask

    task automatic test_noskid_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 12'h017);
        step();
        drive(1'b1, 5'd9, 12'h019);
        #1;
        n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_bp_ready: got %0b want 0", b_in_ready); end
        step();
        n_cmp++; if (b_out_rd !== 5'd7) begin n_err++; $display("FAIL ns_bp_hold: got rd=%0d want 7", b_out_rd); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_bp_ready_back: got %0b want 1", b_in_ready); end
        step();
        n_cmp++; if (b_out_valid !== 1'b1 || b_out_rd !== 5'd9) begin n_err++; $display("FAIL ns_bp_second: got v=%0b rd=%0d want v=1 rd=9", b_out_valid, b_out_rd); end
        drive(1'b0, 5'd0, 12'h0);
        step();
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL ns_bp_drain: got v=%0b want 0", b_out_valid); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (b_flush_count !== 2'd0) begin n_err++; $display("FAIL sat_start: got %0d want 0", b_flush_count); end
        flush = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (b_flush_count !== 2'd3 || a_flush_count !== 16'd3) begin n_err++; $display("FAIL sat_three: got b=%0d a=%0d want 3 3", b_flush_count, a_flush_count); end
        for (int i = 0; i < 2; i++) step();
        n_cmp++; if (b_flush_count !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", b_flush_count); end
        n_cmp++; if (a_flush_count !== 16'd5) begin n_err++; $display("FAIL sat_wide: got %0d want 5", a_flush_count); end
        flush = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall();
        test_async_reset();
        test_noskid_stream();
        test_noskid_backpressure();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined RISC-V datapath, the successor to the fixed-field inter-stage registers. It carries a generic control word, data word and destination-register field between any two stages. It adds a valid/ready handshake, an optional two-entry skid buffer for full throughput under backpressure, flush-to-bubble with destination zeroing, and a saturating flush counter for performance monitoring.

## Interface
- CTRL_W, default 12: width of control word; zeroed on flush.
- DATA_W, default 160: width of data word; never cleared by flush.
- RD_W, default 5: width of destination-register field; zeroed on flush.
- SKID, default 1: 1 = two-entry skid buffer; 0 = single register.
- CNT_W, default 16: width of flush counter.
- clk  in  1  clock; all state updates on the falling edge, matching the rest of the pipelined datapath.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts beat this cycle (combinational).
- in_ctrl  in  CTRL_W  control word.
- in_data  in  DATA_W  data word.
- in_rd  in  RD_W  destination register.
- stall  in  1  hazard-unit hold: block acceptance.
- flush  in  1  hazard-unit flush: kill stored beats.
- out_valid  out  1  beat held in main register.
- out_ready  in  1  downstream consumes beat.
- out_ctrl  out  CTRL_W  main-register control word.
- out_data  out  DATA_W  main-register data word.
- out_rd  out  RD_W  main-register destination.
- flush_count  out  CNT_W  number of flush cycles seen, saturating.

## Operation
- Storage: main entry {valid, ctrl, data, rd} drives out_*. When SKID=1, a second skid entry with the same fields.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Priority at each edge: reset, then flush, then normal.
- Reset (rst_n=0, asynchronous): all valid bits, ctrl, data, rd and flush_count go to 0. in_ready is 0 while in reset.
- Flush:
  - Main and skid valid bits cleared; ctrl and rd in both entries zeroed; data fields keep their values.
  - in_ready=0 during flush, so no input beat is accepted.
  - flush_count increments by 1 per flush cycle and saturates at 2^CNT_W-1.
- in_ready, SKID=0: !flush && !stall && (!out_valid || out_ready).
- in_ready, SKID=1: !flush && !stall && !skid_valid. It does not depend on out_ready.
- Normal update, SKID=0: on Accept, main loads the input; else on Drain, main valid clears (ctrl and rd cleared too).
- Normal update, SKID=1:
  - Drain with skid_valid: main takes skid, and skid empties. Accept is impossible in this case.
  - Accept with (!out_valid || Drain): main loads the input.
  - Accept with out_valid && !Drain: skid loads the input.
  - Drain with no refill: main valid, ctrl and rd clear.
- Stall blocks only the input side. A valid main beat may still drain, leaving a bubble (out_valid=0, out_ctrl=0, out_rd=0).
- Order is preserved: the skid beat always leaves before any later beat.
- Invalid entries always present ctrl=0 and rd=0, so forwarding and writeback never see a phantom destination.

## Timing
- Latency: input to out_* in 1 cycle (next falling edge) when main is free. The skid path adds 1 cycle per backpressured beat.
- Throughput: 1 beat/cycle with SKID=1 under any out_ready pattern. With SKID=0, in_ready stalls in the same cycle as out_ready=0.
- out_* are registered, with no combinational path from any input. in_ready is combinational from flush, stall and state, plus out_ready when SKID=0.
- Flush asserted for N cycles gives out_valid=0 from the first edge onward and flush_count += N.
- Reset released mid-stream: first Accept is possible at the first edge after rst_n rises.

## Test plan
- Streaming: SKID=1, out_ready=1, 4 beats rd=1..4, ctrl=0x0AB. Required: out_rd=1,2,3,4 on consecutive cycles, in_ready stays 1.
- Backpressure: SKID=1, out_ready=0 with beats rd=7 and rd=9. Required: rd=7 in main, rd=9 in skid, in_ready=0; after out_ready=1, out_rd=7 then 9, no loss or duplication.
- Flush: main rd=5, skid rd=6, ctrl=0xFFF, flush=1 for 1 cycle. Required: out_valid=0, out_ctrl=0, out_rd=0, data unchanged, flush_count=1, in_ready=0 during flush.
- Stall: stall=1, main rd=3, out_ready=1. Required: rd=3 drains, next cycle out_valid=0 and out_rd=0, no new beat accepted.
- Saturation: CNT_W=2 with 5 flush cycles. Required: flush_count=3.
- Async reset: rst_n low mid-stream between edges. Required: out_valid=0, all outputs 0 immediately; SKID=0 build also passes the streaming and backpressure ordering checks.
